mac_seq_ctrl: RTL and testbench

Sequencer that wraps the team's combinational 8x8 Wallace-tree multiplier (Multiplier_8x8, Sign input) into a dot-product MAC engine for the NPU.
- Accepts a job of length N via a config pulse.
- Streams N operand pairs in over a valid/ready handshake.
- Registers each product and accumulates it.
- Presents one ACC_W-bit result on a valid/ready output port.
- Sits between the NPU operand fetch/buffer logic and the result writeback.

---
 rtl/mac_seq_pkg.sv | 25 ++
 rtl/Multiplier_8x8.sv | 25 ++
 rtl/mac_seq_ctrl_acc_unit.sv | 75 +++++++
 rtl/mac_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and helpers for the mac_seq_ctrl dot-product engine.
//   state_e  - sequencer states
//   OP_W     - operand width
//   PROD_W   - multiplier product width
//   ext_prod - sign/zero extension of a product to EXT_W bits (callers slice to their width)
package mac_seq_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  // Widest accumulator the extension helper serves; ACC_W must stay below this.
  localparam int unsigned EXT_W  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StHold
  } state_e;

  function automatic logic [EXT_W-1:0] ext_prod(input logic [PROD_W-1:0] prod,
                                                input logic              sign);
    ext_prod = {{(EXT_W-PROD_W){sign & prod[PROD_W-1]}}, prod};
  endfunction

endpackage

// File: rtl/Multiplier_8x8.sv
// Multiplier_8x8: combinational 8x8 multiplier with selectable operand signedness.
// Ports:
//   i_a, i_b  - 8-bit operands
//   i_sign    - 1: two's-complement operands, 0: unsigned
//   o_prod    - 16-bit product
module Multiplier_8x8
  import mac_seq_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  input  logic              i_sign,
  output logic [PROD_W-1:0] o_prod
);

  logic [PROD_W-1:0] w_a;
  logic [PROD_W-1:0] w_b;

  // The low PROD_W bits of a product of extended operands are exact for both signednesses.
  always_comb begin
    w_a    = {{(PROD_W-OP_W){i_sign & i_a[OP_W-1]}}, i_a};
    w_b    = {{(PROD_W-OP_W){i_sign & i_b[OP_W-1]}}, i_b};
    o_prod = w_a * w_b;
  end

endmodule

// File: rtl/mac_seq_ctrl_acc_unit.sv
// mac_acc_unit: accumulator register with overflow detection.
// Optional feature: define MAC_SEQ_SAT_EN to clamp an overflowing accumulate to the limit
// (unsigned max, or signed max/min) instead of wrapping.
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_clr        - clear acc and sticky overflow (job start)
//   i_en         - add i_prod into acc this cycle
//   i_sign       - 1: signed accumulate, 0: unsigned
//   i_prod       - product to add (extended per i_sign)
//   o_acc        - accumulator value
//   o_ovf        - sticky overflow flag
module mac_acc_unit
  import mac_seq_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_sign,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  localparam int unsigned MSB = ACC_W - 1;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [EXT_W-1:0] w_ext_full;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_unused_ext;

  assign w_ext_full   = ext_prod(i_prod, i_sign);
  assign w_ext        = w_ext_full[ACC_W-1:0];
  assign w_unused_ext = ^w_ext_full[EXT_W-1:ACC_W];

  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, w_ext};
    // Signed overflow: like-signed operands giving a differently-signed result.
    w_ovf = i_sign ? ((r_acc[MSB] == w_ext[MSB]) && (w_sum[MSB] != r_acc[MSB]))
                   : w_sum[ACC_W];
`ifdef MAC_SEQ_SAT_EN
    if (!w_ovf) begin
      w_acc_next = w_sum[ACC_W-1:0];
    end else if (!i_sign) begin
      w_acc_next = '1;
    end else if (r_acc[MSB]) begin
      w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    w_acc_next = w_sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_acc_next;
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: dot-product MAC sequencer around Multiplier_8x8.
// A cfg_start pulse in IDLE launches a job of i_cfg_len operand pairs; each accepted pair's
// product is registered and accumulated; the result is held on the res port until taken.
// Optional feature: MAC_SEQ_SAT_EN selects saturating accumulation (see mac_acc_unit).
// Ports:
//   i_clk, i_rst                      - clock, synchronous active-high reset
//   i_cfg_start/len/sign, o_busy      - job configuration and busy status
//   i_op_valid, o_op_ready, i_op_a/b  - operand pair stream
//   o_res_valid, i_res_ready          - result handshake
//   o_res_data, o_res_ovf             - accumulated result and sticky overflow
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_start,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_cfg_sign,
  output logic             o_busy,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [OP_W-1:0]  i_op_a,
  input  logic [OP_W-1:0]  i_op_b,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [ACC_W-1:0] o_res_data,
  output logic             o_res_ovf
);

  state_e            r_state;
  state_e            w_state_next;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_sign;
  logic [PROD_W-1:0] r_prod;
  logic              r_prod_v;
  logic [PROD_W-1:0] w_prod;
  logic              w_start;
  logic              w_op_hs;

  Multiplier_8x8 u_mult (
    .i_a    (i_op_a),
    .i_b    (i_op_b),
    .i_sign (r_sign),
    .o_prod (w_prod)
  );

  mac_acc_unit #(
    .ACC_W (ACC_W)
  ) u_acc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_start),
    .i_en   (r_prod_v),
    .i_sign (r_sign),
    .i_prod (r_prod),
    .o_acc  (o_res_data),
    .o_ovf  (o_res_ovf)
  );

  assign w_op_hs = o_op_ready & i_op_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b1;
    o_op_ready   = 1'b0;
    o_res_valid  = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_cfg_start) begin
          w_start      = 1'b1;
          w_state_next = (i_cfg_len == '0) ? StHold : StRun;
        end
      end
      StRun: begin
        o_op_ready = 1'b1;
        if (i_op_valid && (r_remaining == LEN_W'(1))) begin
          w_state_next = StFlush;
        end
      end
      // The last product is being accumulated this cycle.
      StFlush: w_state_next = StHold;
      StHold: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_remaining <= '0;
      r_sign      <= 1'b0;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
    end else begin
      r_prod_v <= 1'b0;
      if (w_start) begin
        r_remaining <= i_cfg_len;
        r_sign      <= i_cfg_sign;
      end
      if (w_op_hs) begin
        r_prod      <= w_prod;
        r_prod_v    <= 1'b1;
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_len;
  logic        cfg_sign;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic        res_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .ACC_W (24),
    .LEN_W (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_start (cfg_start),
    .i_cfg_len   (cfg_len),
    .i_cfg_sign  (cfg_sign),
    .o_busy      (busy),
    .i_op_valid  (op_valid),
    .o_op_ready  (op_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_ovf   (res_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic sign, input logic [15:0] len);
    cfg_start = 1'b1;
    cfg_sign  = sign;
    cfg_len   = len;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, res_valid, 1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_sign = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);

    // Unsigned basic, op_valid held high, exact latency.
    start_job(1'b0, 16'd3);
    chk("u_busy", busy, 1);
    chk("u_op_ready", op_ready, 1);
    op_valid = 1'b1; op_a = 8'd255; op_b = 8'd255;
    tick(); tick(); tick();
    op_valid = 1'b0;
    chk("u_flush_ready", op_ready, 0);
    chk("u_flush_valid", res_valid, 0);
    tick();
    chk("u_lat_valid", res_valid, 1);
    chk("u_data", res_data, 32'd195075);
    chk("u_ovf", res_ovf, 0);
    take_res();
    chk("u_idle_busy", busy, 0);
    chk("u_idle_valid", res_valid, 0);

    // Signed mix.
    start_job(1'b1, 16'd2);
    feed(8'h80, 8'h80);
    feed(8'h7f, 8'hff);
    wait_res("s_timeout", 10);
    chk("s_data", res_data, 32'd16257);
    chk("s_ovf", res_ovf, 0);
    take_res();

    // Zero length.
    chk("z_pre_ready", op_ready, 0);
    start_job(1'b0, 16'd0);
    chk("z_valid", res_valid, 1);
    chk("z_data", res_data, 0);
    chk("z_ready", op_ready, 0);
    take_res();
    chk("z_idle", busy, 0);

    // Backpressure: toggling op_valid, ignored cfg_start pulses, held result.
    start_job(1'b0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op_a = 8'd2; op_b = 8'd3;
      cfg_start = (i == 1); cfg_len = '0;
      tick();
      op_valid = 1'b0; cfg_start = 1'b0;
      tick();
    end
    chk("bp_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cfg_start = 1'b1; cfg_len = 16'd0;
      tick();
      chk("bp_hold_data", res_data, 32'd24);
      chk("bp_hold_valid", res_valid, 1);
    end
    cfg_start = 1'b0;
    take_res();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", res_valid, 0);

    // Unsigned overflow.
    start_job(1'b0, 16'd300);
    op_valid = 1'b1; op_a = 8'd255; op_b = 8'd255;
    for (int i = 0; i < 300; i++) tick();
    op_valid = 1'b0;
    wait_res("uo_timeout", 10);
`ifdef MAC_SEQ_SAT_EN
    chk("uo_data", res_data, 32'd16777215);
`else
    chk("uo_data", res_data, 32'd2730284);
`endif
    chk("uo_ovf", res_ovf, 1);
    take_res();

    // Signed positive overflow: 513 * 16384.
    start_job(1'b1, 16'd513);
    op_valid = 1'b1; op_a = 8'h80; op_b = 8'h80;
    for (int i = 0; i < 513; i++) tick();
    op_valid = 1'b0;
    wait_res("so_timeout", 10);
`ifdef MAC_SEQ_SAT_EN
    chk("so_data", res_data, 32'h7fffff);
`else
    chk("so_data", res_data, 32'h804000);
`endif
    chk("so_ovf", res_ovf, 1);
    take_res();

    // Reset mid-job, then a fresh job.
    start_job(1'b0, 16'd5);
    feed(8'd9, 8'd9);
    feed(8'd9, 8'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_op_ready", op_ready, 0);
    chk("mr_res_valid", res_valid, 0);
    chk("mr_res_data", res_data, 0);
    start_job(1'b0, 16'd1);
    feed(8'd7, 8'd6);
    wait_res("mr_timeout", 10);
    chk("mr_new_data", res_data, 32'd42);
    chk("mr_new_ovf", res_ovf, 0);
    take_res();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
